idelay_sweep_ctrl: RTL and testbench

- Sequencer between the IDELAY tap input and the UART message formatter in the IDELAY histogram design.
- On START, steps the IDELAY tap from 0 to TAPS-1. At each tap it waits a settle interval, counts per-cycle error flags over a fixed window, then emits one (tap, error_count) record on a valid/ready stream.
- The formatter consumes the records and prints one histogram line per tap.

---
 rtl/idelay_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_idelay_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_sweep_ctrl.sv
// idelay_sweep_ctrl: sweeps the IDELAY tap 0..TAPS-1, counts errors per tap, emits (tap, count) records
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          sweep request, sampled only while idle
//   abort_i          synchronous abort back to idle (ignored while idle)
//   err_i            per-cycle error flag from the checker
//   delay_o          registered IDELAY tap value
//   delay_ld_o       one-cycle load strobe when delay_o changes
//   busy_o           high whenever a sweep is in progress
//   done_o           one-cycle pulse after the last record is accepted
//   out_valid_o      record valid, held until out_ready_i
//   out_ready_i      record accept
//   out_tap_o        tap index of the record
//   out_count_o      saturating error count of the record
module idelay_sweep_ctrl #(
   parameter int TAPS          = 32,
   parameter int SETTLE_CYCLES = 16,
   parameter int WINDOW_LOG2   = 16,
   parameter int COUNT_WIDTH   = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   err_i,
   output logic [4:0]             delay_o,
   output logic                   delay_ld_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [4:0]             out_tap_o,
   output logic [COUNT_WIDTH-1:0] out_count_o
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, COUNT, EMIT} state_t;
   state_t                 state_q, state_d;
   logic [4:0]             tap_q, tap_d, delay_q, delay_d, out_tap_q, out_tap_d;
   logic [SW-1:0]          set_q, set_d;
   logic [WINDOW_LOG2-1:0] win_q, win_d;
   logic [COUNT_WIDTH-1:0] err_q, err_d, err_inc, out_count_q, out_count_d;
   logic                   delay_ld_q, busy_q, done_q, done_d, valid_q, valid_d;
   // saturating increment: holds at all-ones instead of wrapping
   assign err_inc = (err_i && err_q != '1) ? err_q + COUNT_WIDTH'(1) : err_q;
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      set_d       = set_q;
      win_d       = win_q;
      err_d       = err_q;
      valid_d     = valid_q;
      out_tap_d   = out_tap_q;
      out_count_d = out_count_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = LOAD;
            tap_d   = '0;
         end
         LOAD: begin
            set_d   = '0;
            win_d   = '0;
            err_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            set_d = set_q + SW'(1);
            if (set_q == SW'(SETTLE_CYCLES - 1)) state_d = COUNT;
         end
         COUNT: begin
            // window counter wraps to zero on its last cycle, ready for the next tap
            win_d = win_q + WINDOW_LOG2'(1);
            err_d = err_inc;
            if (win_q == '1) begin
               state_d     = EMIT;
               valid_d     = 1'b1;
               out_tap_d   = tap_q;
               out_count_d = err_inc;
            end
         end
         EMIT: if (out_ready_i) begin
            valid_d = 1'b0;
            if (tap_q == 5'(TAPS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = LOAD;
               tap_d   = tap_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // abort overrides any transition, including a simultaneous handshake
      if (abort_i && state_q != IDLE) begin
         state_d = IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
         tap_d   = '0;
         set_d   = '0;
         win_d   = '0;
         err_d   = '0;
      end
      // DELAY is loaded on entry to LOAD so it and its strobe are visible during LOAD
      delay_d = (state_d == LOAD) ? tap_d : delay_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         set_q       <= '0;
         win_q       <= '0;
         err_q       <= '0;
         delay_q     <= '0;
         delay_ld_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         out_tap_q   <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         set_q       <= set_d;
         win_q       <= win_d;
         err_q       <= err_d;
         delay_q     <= delay_d;
         delay_ld_q  <= state_d == LOAD;
         busy_q      <= state_d != IDLE;
         done_q      <= done_d;
         valid_q     <= valid_d;
         out_tap_q   <= out_tap_d;
         out_count_q <= out_count_d;
      end
   end
   assign delay_o     = delay_q;
   assign delay_ld_o  = delay_ld_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign out_valid_o = valid_q;
   assign out_tap_o   = out_tap_q;
   assign out_count_o = out_count_q;
endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// tb_idelay_sweep_ctrl: randomized bench for idelay_sweep_ctrl against a tap/position timeline model
module tb_idelay_sweep_ctrl;
   localparam int TAPS = 4, S = 2, WL = 3, W = 8;
   logic clk = 0, rst_n = 0, start = 0, abort = 0, err = 0, ready = 1;
   logic [4:0]  d_delay, d_tap, s_delay, s_tap;
   logic        d_ld, d_busy, d_done, d_valid, s_ld, s_busy, s_done, s_valid;
   logic [23:0] d_count;
   logic [1:0]  s_count;
   int total = 0, bad = 0, cyc = 0;
   int err_mode = 0, rdy_mode = 0;
   bit chk_en = 0;
   always #5 clk = ~clk;

   idelay_sweep_ctrl #(.TAPS(TAPS), .SETTLE_CYCLES(S), .WINDOW_LOG2(WL), .COUNT_WIDTH(24)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .err_i(err),
      .delay_o(d_delay), .delay_ld_o(d_ld), .busy_o(d_busy), .done_o(d_done),
      .out_valid_o(d_valid), .out_ready_i(ready), .out_tap_o(d_tap), .out_count_o(d_count));
   idelay_sweep_ctrl #(.TAPS(TAPS), .SETTLE_CYCLES(S), .WINDOW_LOG2(WL), .COUNT_WIDTH(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .err_i(err),
      .delay_o(s_delay), .delay_ld_o(s_ld), .busy_o(s_busy), .done_o(s_done),
      .out_valid_o(s_valid), .out_ready_i(ready), .out_tap_o(s_tap), .out_count_o(s_count));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a sweep is a position counter within the current tap:
   // 0 = load, 1..S settle, S+1..S+W counting window, beyond that waiting for acceptance.
   bit m_active = 0;
   int m_tap = 0, m_pos = 0, m_cnt = 0;
   int e_delay = 0, e_ld = 0, e_done = 0, e_valid = 0, e_tap = 0, e_cnt = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_tap = 0; m_pos = 0; m_cnt = 0;
         e_delay = 0; e_ld = 0; e_done = 0; e_valid = 0; e_tap = 0; e_cnt = 0;
      end else begin
         e_ld = 0; e_done = 0;
         if (!m_active) begin
            if (start) begin m_active = 1; m_tap = 0; m_pos = 0; m_cnt = 0; e_ld = 1; e_delay = 0; end
         end else if (abort) begin
            m_active = 0; e_valid = 0;
         end else if (m_pos > S + W) begin
            if (ready) begin
               e_valid = 0;
               if (m_tap == TAPS - 1) begin m_active = 0; e_done = 1; end
               else begin m_tap++; m_pos = 0; m_cnt = 0; e_ld = 1; e_delay = m_tap; end
            end
         end else begin
            if (m_pos > S) m_cnt += int'(err);
            if (m_pos == S + W) begin e_valid = 1; e_tap = m_tap; e_cnt = m_cnt; end
            m_pos++;
         end
      end
   end

   always @(posedge clk) cyc++;

   // per-cycle compare plus event statistics used by the literal checks
   int ld_n = 0, done_n = 0, done_cyc = 0;
   int ld_cyc[$], ld_val[$], rec_tap[$], rec_cnt[$], rec_sat[$];
   always @(negedge clk) if (chk_en) begin
      chk("delay", d_delay, e_delay);
      chk("delay_ld", d_ld, e_ld);
      chk("busy", d_busy, m_active);
      chk("done", d_done, e_done);
      chk("out_valid", d_valid, e_valid);
      chk("out_tap", d_tap, e_tap);
      chk("out_count", d_count, e_cnt);
      chk("sat_valid", s_valid, e_valid);
      chk("sat_count", s_count, e_cnt > 3 ? 3 : e_cnt);
      if (d_ld) begin ld_n++; ld_cyc.push_back(cyc); ld_val.push_back(int'(d_delay)); end
      if (d_done) begin done_n++; done_cyc = cyc; end
   end
   always @(posedge clk) if (rst_n && d_valid && ready && !abort) begin
      rec_tap.push_back(int'(d_tap));
      rec_cnt.push_back(int'(d_count));
      rec_sat.push_back(int'(s_count));
   end

   always @(negedge clk) begin
      #1;
      case (err_mode)
         0: err = 0;
         1: err = 1;
         2: err = m_active && m_tap == 2;
         default: err = 1'($urandom_range(0, 1));
      endcase
      if (rdy_mode == 1) ready = 1'($urandom_range(0, 1));
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask
   task automatic clr();
      ld_cyc.delete(); ld_val.delete(); rec_tap.delete(); rec_cnt.delete(); rec_sat.delete();
      ld_n = 0; done_n = 0;
   endtask
   task automatic pulse_start();
      start = 1; cyc_n(1); start = 0;
   endtask
   task automatic wait_done(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         cyc_n(1);
         if (d_done) break;
      end
      chk("sweep_done_in_time", k < budget, 1);
   endtask

   initial begin
      int k;
      cyc_n(1);
      chk_en = 1;
      cyc_n(2);
      chk("rst_busy", d_busy, 0);
      chk("rst_count", d_count, 0);
      rst_n = 1;
      cyc_n(2);

      // nominal sweep, no errors
      clr(); err_mode = 0; rdy_mode = 0; ready = 1;
      pulse_start();
      wait_done(200);
      cyc_n(3);
      chk("s1_records", rec_tap.size(), 4);
      chk("s1_ld_pulses", ld_n, 4);
      chk("s1_done_pulses", done_n, 1);
      for (int i = 0; i < 4 && i < rec_tap.size(); i++) begin
         chk("s1_rec_tap", rec_tap[i], i);
         chk("s1_rec_cnt", rec_cnt[i], 0);
         chk("s1_ld_val", ld_val[i], i);
      end
      for (int i = 0; i < 3 && i + 1 < ld_cyc.size(); i++) chk("s1_tap_period", ld_cyc[i+1] - ld_cyc[i], 12);
      if (ld_cyc.size() == 4) chk("s1_done_latency", done_cyc - ld_cyc[3], 12);

      // errors only during tap 2; settle-phase errors ignored
      clr(); err_mode = 2;
      pulse_start();
      wait_done(200);
      cyc_n(2);
      chk("s2_records", rec_cnt.size(), 4);
      for (int i = 0; i < 4 && i < rec_cnt.size(); i++) begin
         chk("s2_rec_cnt", rec_cnt[i], i == 2 ? 8 : 0);
         chk("s2_sat_cnt", rec_sat[i], i == 2 ? 3 : 0);
      end

      // constant errors: 2-bit counter saturates at 3
      clr(); err_mode = 1;
      pulse_start();
      wait_done(200);
      cyc_n(2);
      chk("s3_records", rec_sat.size(), 4);
      for (int i = 0; i < rec_sat.size(); i++) begin
         chk("s3_sat_cnt", rec_sat[i], 3);
         chk("s3_full_cnt", rec_cnt[i], 8);
      end

      // backpressure at tap 1 for 10 cycles
      clr(); err_mode = 3;
      pulse_start();
      for (k = 0; k < 200 && !(m_active && m_tap == 1 && m_pos > S + W); k++) cyc_n(1);
      chk("s4_reach_emit", k < 200, 1);
      ready = 0;
      k = e_cnt;
      repeat (10) begin
         cyc_n(1);
         chk("s4_hold_valid", d_valid, 1);
         chk("s4_hold_tap", d_tap, 1);
         chk("s4_hold_cnt", d_count, k);
         chk("s4_hold_delay", d_delay, 1);
         chk("s4_hold_no_ld", d_ld, 0);
      end
      ready = 1;
      wait_done(200);
      cyc_n(2);
      chk("s4_records", rec_tap.size(), 4);

      // abort mid-count at tap 2, then restart
      clr();
      pulse_start();
      for (k = 0; k < 200 && !(m_active && m_tap == 2 && m_pos == S + 4); k++) cyc_n(1);
      chk("s5_reach_count", k < 200, 1);
      abort = 1; cyc_n(1); abort = 0;
      chk("s5_busy", d_busy, 0);
      chk("s5_valid", d_valid, 0);
      chk("s5_delay", d_delay, 2);
      chk("s5_done", d_done, 0);
      cyc_n(3);
      chk("s5_no_done", done_n, 0);
      start = 1; cyc_n(1);
      chk("s5_restart_ld", d_ld, 1);
      chk("s5_restart_delay", d_delay, 0);
      start = 0;
      wait_done(200);

      // asynchronous reset in settle of tap 1
      cyc_n(2);
      pulse_start();
      for (k = 0; k < 200 && !(m_active && m_tap == 1 && m_pos == 1); k++) cyc_n(1);
      chk("s6_reach_settle", k < 200, 1);
      #2 rst_n = 0;
      #1;
      chk("s6_rst_delay", d_delay, 0);
      chk("s6_rst_ld", d_ld, 0);
      chk("s6_rst_busy", d_busy, 0);
      chk("s6_rst_done", d_done, 0);
      chk("s6_rst_valid", d_valid, 0);
      chk("s6_rst_tap", d_tap, 0);
      chk("s6_rst_count", d_count, 0);
      cyc_n(2);
      rst_n = 1;
      cyc_n(2);

      // start spam while busy yields exactly one sweep
      clr(); rdy_mode = 1;
      pulse_start();
      for (k = 0; k < 400 && !d_done; k++) begin
         start = m_active ? 1'($urandom_range(0, 1)) : 1'b0;
         cyc_n(1);
      end
      start = 0;
      chk("s7_done_in_time", k < 400, 1);
      cyc_n(3);
      chk("s7_records", rec_tap.size(), 4);
      chk("s7_done_pulses", done_n, 1);

      // fully random traffic with occasional aborts
      repeat (1500) begin
         start = !m_active && $urandom_range(0, 7) == 0;
         abort = $urandom_range(0, 40) == 0;
         cyc_n(1);
      end
      start = 0; abort = 0;
      for (k = 0; k < 500 && m_active; k++) cyc_n(1);
      chk("s8_idle_in_time", k < 500, 1);
      cyc_n(2);
      chk("s8_idle", d_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
